semente_lfsr: RTL and testbench

SEMENTE_LFSR -- requirements
Module: semente_lfsr

---
 rtl/semente_lfsr_pkg.sv | 17 +
 rtl/lfsr14_step.sv | 14 +
 rtl/semente_lfsr.sv | 84 ++++++++
 tb/tb_semente_lfsr.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/semente_lfsr_pkg.sv
// rtl/semente_lfsr_pkg.sv - shared constants and FSM encoding for the seed LFSR
package semente_lfsr_pkg;

  localparam int unsigned LFSR_W = 14;
  localparam int unsigned CNT_W  = 4;

  // Feedback taps 14,5,3,1 expressed as state bit positions 13,4,2,0
  localparam logic [LFSR_W-1:0] TAP_MASK   = 14'h2015;
  localparam logic [LFSR_W-1:0] RESET_SEED = 14'h0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr14_step.sv
// rtl/lfsr14_step.sv - combinational Fibonacci shift-left step of the 14-bit LFSR
import semente_lfsr_pkg::*;

module lfsr14_step (
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  // Shift left and insert the parity of the tapped bits at bit 0
  always_comb begin
    nxt = {cur[LFSR_W-2:0], ^(cur & TAP_MASK)};
  end

endmodule

// File: rtl/semente_lfsr.sv
// rtl/semente_lfsr.sv - seed generator FSM; optional gerados counter under SEMENTE_COUNT_EN
import semente_lfsr_pkg::*;

module semente_lfsr #(
  parameter int unsigned STEPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              carregar,
  input  logic [LFSR_W-1:0] semente_in,
  input  logic              pedido,
  output logic [LFSR_W-1:0] semente,
  output logic              valido,
  output logic              ocupado
`ifdef SEMENTE_COUNT_EN
  ,
  output logic [15:0]       gerados
`endif
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] step_next;

  lfsr14_step u_step (
    .cur (semente),
    .nxt (step_next)
  );

  // Request FSM: load/accept in IDLE, shift STEPS times in RUN, pulse valido in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      semente <= RESET_SEED;
      cnt     <= '0;
      valido  <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valido <= 1'b0;
          if (carregar) begin
            // A zero seed would lock the LFSR, so it is replaced by the reset seed
            semente <= (semente_in == '0) ? RESET_SEED : semente_in;
          end else if (pedido) begin
            state   <= ST_RUN;
            cnt     <= CNT_W'(STEPS);
            ocupado <= 1'b1;
          end
        end
        ST_RUN: begin
          semente <= step_next;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= ST_DONE;
            valido <= 1'b1;
          end
        end
        ST_DONE: begin
          valido  <= 1'b0;
          ocupado <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          valido  <= 1'b0;
          ocupado <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SEMENTE_COUNT_EN
  // Count completed requests, holding at the maximum instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gerados <= '0;
    end else if (valido && (gerados != 16'hFFFF)) begin
      gerados <= gerados + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_semente_lfsr.sv
// tb/tb_semente_lfsr.sv - self-checking bench for semente_lfsr (STEPS=4 and STEPS=1 instances)
module tb_semente_lfsr;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        car_a, ped_a, car_b, ped_b;
  logic [13:0] sin_a, sin_b;
  logic [13:0] sem_a, sem_b;
  logic        val_a, val_b, ocu_a, ocu_b;
`ifdef SEMENTE_COUNT_EN
  logic [15:0] ger_a, ger_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  semente_lfsr #(.STEPS(4)) u_a (
    .clk(clk), .rst_n(rst_a), .carregar(car_a), .semente_in(sin_a), .pedido(ped_a),
    .semente(sem_a), .valido(val_a), .ocupado(ocu_a)
`ifdef SEMENTE_COUNT_EN
    , .gerados(ger_a)
`endif
  );

  semente_lfsr #(.STEPS(1)) u_b (
    .clk(clk), .rst_n(rst_b), .carregar(car_b), .semente_in(sin_b), .pedido(ped_b),
    .semente(sem_b), .valido(val_b), .ocupado(ocu_b)
`ifdef SEMENTE_COUNT_EN
    , .gerados(ger_b)
`endif
  );

  typedef struct {
    logic        car;
    logic        ped;
    logic [13:0] sin;
    logic [13:0] exp_sem;
    logic        exp_val;
    logic        exp_ocu;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference step: shift left within 14 bits, append parity of taps 14,5,3,1
  function automatic logic [13:0] ref_step(input logic [13:0] s);
    int ones;
    ones = int'(s[13]) + int'(s[4]) + int'(s[2]) + int'(s[0]);
    return ((s << 1) & 14'h3FFF) | 14'(ones % 2);
  endfunction

  initial begin
    int          m_left;
    logic [13:0] m_seed;
    int          m_gen;
    int          bad_pulse;
    int          pulses;
    int          trace_err;
    int          repeats;
    int          budget;
    logic [13:0] seed0;
    logic [13:0] m_sem;
    bit          seen[16384];

    vecs[0]  = '{1'b0, 1'b1, 14'h0000, 14'h0001, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 14'h0000, 14'h0003, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 14'h0000, 14'h0007, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 14'h0000, 14'h000E, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 14'h0000, 14'h001D, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 14'h0000, 14'h001D, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 14'h0000, 14'h0001, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 14'h1234, 14'h1234, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 14'h0000, 14'h1234, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 14'h0000, 14'h2468, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 14'h3FFF, 14'h08D1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 14'h0000, 14'h11A2, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 14'h0000, 14'h2344, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 14'h0000, 14'h2344, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 14'h0000, 14'h2344, 1'b0, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0;
    car_a = 1'b0; ped_a = 1'b0; sin_a = '0;
    car_b = 1'b0; ped_b = 1'b0; sin_b = '0;
    repeat (3) @(negedge clk);

    check("reset_semente", 32'(sem_a), 32'h0001);
    check("reset_valido", 32'(val_a), 32'h0);
    check("reset_ocupado", 32'(ocu_a), 32'h0);
`ifdef SEMENTE_COUNT_EN
    check("reset_gerados", 32'(ger_a), 32'h0);
`endif
    rst_a = 1'b1; rst_b = 1'b1;

    // Directed table on the STEPS=4 instance
    for (int i = 0; i < 15; i++) begin
      car_a = vecs[i].car; ped_a = vecs[i].ped; sin_a = vecs[i].sin;
      tick();
      check($sformatf("vec%0d_semente", i), 32'(sem_a), 32'(vecs[i].exp_sem));
      check($sformatf("vec%0d_valido", i), 32'(val_a), 32'(vecs[i].exp_val));
      check($sformatf("vec%0d_ocupado", i), 32'(ocu_a), 32'(vecs[i].exp_ocu));
    end
    car_a = 1'b0; ped_a = 1'b0;
`ifdef SEMENTE_COUNT_EN
    check("table_gerados", 32'(ger_a), 32'd2);
`endif

    // Load all-ones then a single-step request on the STEPS=1 instance
    car_b = 1'b1; sin_b = 14'h3FFF;
    tick();
    check("b_load_3fff", 32'(sem_b), 32'h3FFF);
    car_b = 1'b0; ped_b = 1'b1;
    tick();
    check("b_run_ocupado", 32'(ocu_b), 32'h1);
    ped_b = 1'b0;
    tick();
    check("b_step1_valido", 32'(val_b), 32'h1);
    check("b_step1_semente", 32'(sem_b), 32'h3FFE);
    tick();
    check("b_done_release", 32'({val_b, ocu_b}), 32'h0);

    // Reset during the second RUN cycle aborts the request
    ped_a = 1'b1;
    tick();
    ped_a = 1'b0;
    tick();
    #2 rst_a = 1'b0;
    #1;
    check("abort_semente", 32'(sem_a), 32'h0001);
    check("abort_ocupado", 32'(ocu_a), 32'h0);
    check("abort_valido", 32'(val_a), 32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    bad_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (val_a || ocu_a) bad_pulse++;
    end
    check("abort_no_valido", 32'(bad_pulse), 32'h0);
    check("abort_idle_semente", 32'(sem_a), 32'h0001);

    // Randomized traffic against a transaction-level model
    m_left = 0; m_seed = 14'h0001; m_gen = 0;
    for (int i = 0; i < 600; i++) begin
      car_a = ($urandom_range(0, 7) == 0);
      ped_a = ($urandom_range(0, 3) == 0);
      sin_a = ($urandom_range(0, 3) == 0) ? 14'h0000 : 14'($urandom);
      tick();
      if (m_left == 0) begin
        if (car_a) m_seed = (sin_a == 14'h0000) ? 14'h0001 : sin_a;
        else if (ped_a) m_left = 5;
      end else begin
        if (m_left > 1) m_seed = ref_step(m_seed);
        m_left--;
        if (m_left == 1) m_gen++;
      end
      check($sformatf("rand%0d", i), {16'h0, sem_a, val_a, ocu_a},
            {16'h0, m_seed, (m_left == 1), (m_left > 0)});
    end
    car_a = 1'b0; ped_a = 1'b0;
    tick(); tick();
`ifdef SEMENTE_COUNT_EN
    check("rand_gerados", 32'(ger_a), 32'(m_gen));
`endif

    // Full period with back-to-back single-step requests
    seed0 = 14'($urandom_range(1, 16383));
    car_b = 1'b1; sin_b = seed0;
    tick();
    car_b = 1'b0;
    check("period_seed_load", 32'(sem_b), 32'(seed0));
    seen[seed0] = 1'b1;
    m_sem = seed0;
    pulses = 0; trace_err = 0; repeats = 0; budget = 0;
    ped_b = 1'b1;
    while (pulses < 16383 && budget < 16383 * 3 + 100) begin
      tick();
      budget++;
      if (val_b) begin
        pulses++;
        m_sem = ref_step(m_sem);
        if (sem_b !== m_sem) trace_err++;
        if (pulses < 16383) begin
          if (seen[sem_b]) repeats++;
          seen[sem_b] = 1'b1;
        end
        if (pulses == 16383) ped_b = 1'b0;
      end
    end
    ped_b = 1'b0;
    check("period_pulses", 32'(pulses), 32'd16383);
    check("period_trace", 32'(trace_err), 32'd0);
    check("period_no_early_repeat", 32'(repeats), 32'd0);
    check("period_return_seed", 32'(sem_b), 32'(seed0));
    tick(); tick();
    check("period_idle", 32'({val_b, ocu_b}), 32'h0);
`ifdef SEMENTE_COUNT_EN
    check("period_gerados", 32'(ger_b), 32'd16384);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
